coord_display_driver: RTL and testbench

Downstream consumer of the processor's `xCoord`/`yCoord` register-file taps. It converts the two 32-bit coordinates to 4-digit decimal with a sequential double-dabble engine. It time-multiplexes the result onto an 8-digit common-anode seven-segment display: y on digits 0–3, x on digits 4–7. It sits between the pipeline top level and the board pins.

---
 rtl/coord_display_driver_if.sv | 13 +
 rtl/coord_display_driver.sv | 124 ++++++++++++
 tb/tb_coord_display_driver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/coord_display_driver_if.sv
// coord_display_driver_if: coordinate taps in, seven-segment pins and status out
interface coord_display_driver_if;
  logic [31:0] xCoord;
  logic [31:0] yCoord;
  logic [6:0]  Seg;
  logic [7:0]  An;
  logic        Dp;
  logic        Busy;
  logic        XOvf;
  logic        YOvf;
  modport master (output xCoord, yCoord, input Seg, An, Dp, Busy, XOvf, YOvf);
  modport slave  (input xCoord, yCoord, output Seg, An, Dp, Busy, XOvf, YOvf);
endinterface

// File: rtl/coord_display_driver.sv
// coord_display_driver: double-dabble x/y to BCD and scan them onto an 8-digit display
module coord_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  coord_display_driver_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, CONV_X, CONV_Y, UPDATE} state_t;
  state_t          r_state, w_next;
  logic [31:0]     r_xlast, r_ylast;
  logic [29:0]     r_sh;
  logic [3:0]      r_cnt;
  logic [15:0]     r_xtmp, r_xdisp, r_ydisp;
  logic            r_xovf_p, r_yovf_p, r_xovf, r_yovf;
  logic [PW-1:0]   r_pre;
  logic [2:0]      r_idx;
  logic            w_start, w_last, w_blank;
  logic [13:0]     w_xclamp, w_yclamp;
  logic [29:0]     w_adj, w_step;
  logic [15:0]     w_field, w_upper;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg;
  assign w_start  = (r_state == IDLE) && ((bus.xCoord != r_xlast) || (bus.yCoord != r_ylast));
  assign w_last   = (r_cnt == 4'd13);
  assign w_xclamp = (bus.xCoord > 32'd9999) ? 14'd9999 : bus.xCoord[13:0];
  assign w_yclamp = (r_ylast > 32'd9999) ? 14'd9999 : r_ylast[13:0];
  // double-dabble step: bump BCD nibbles >= 5 by 3, then shift the whole word left
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 4; i++)
      w_adj[14+4*i +: 4] = (r_sh[14+4*i +: 4] >= 4'd5) ? r_sh[14+4*i +: 4] + 4'd3 : r_sh[14+4*i +: 4];
  end
  assign w_step = {w_adj[28:0], 1'b0};
  // state register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: x and y each take exactly 14 iterations, then a single update cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? CONV_X : IDLE;
      CONV_X:  w_next = w_last ? CONV_Y : CONV_X;
      CONV_Y:  w_next = w_last ? UPDATE : CONV_Y;
      default: w_next = IDLE;
    endcase
  end
  // capture, conversion datapath and display registers
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_xlast  <= '0;
      r_ylast  <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_xtmp   <= '0;
      r_xdisp  <= '0;
      r_ydisp  <= '0;
      r_xovf_p <= 1'b0;
      r_yovf_p <= 1'b0;
      r_xovf   <= 1'b0;
      r_yovf   <= 1'b0;
    end else begin
      if (w_start) begin
        r_xlast  <= bus.xCoord;
        r_ylast  <= bus.yCoord;
        r_sh     <= {16'd0, w_xclamp};
        r_xovf_p <= bus.xCoord > 32'd9999;
        r_yovf_p <= bus.yCoord > 32'd9999;
        r_cnt    <= '0;
      end
      if (r_state == CONV_X || r_state == CONV_Y) begin
        r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        r_sh  <= (w_last && r_state == CONV_X) ? {16'd0, w_yclamp} : w_step;
      end
      if (r_state == CONV_X && w_last) r_xtmp <= w_step[29:14];
      if (r_state == UPDATE) begin
        r_xdisp <= r_xtmp;
        r_ydisp <= r_sh[29:14];
        r_xovf  <= r_xovf_p;
        r_yovf  <= r_yovf_p;
      end
    end
  // digit scan: each digit held for REFRESH_DIV cycles, independent of conversion
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  assign w_field = r_idx[2] ? r_xdisp : r_ydisp;
  assign w_digit = w_field[{r_idx[1:0], 2'b00} +: 4];
  assign w_upper = w_field >> {r_idx[1:0], 2'b00};
  assign w_blank = BLANK_LZ && (r_idx[1:0] != 2'd0) && (w_upper == 16'd0);
  // active-low seven-segment decode {g,f,e,d,c,b,a}
  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
  end
  assign bus.Seg  = w_blank ? 7'b1111111 : w_seg;
  assign bus.An   = ~(8'd1 << r_idx);
  assign bus.Dp   = (r_idx != 3'd4);
  assign bus.Busy = (r_state != IDLE);
  assign bus.XOvf = r_xovf;
  assign bus.YOvf = r_yovf;
endmodule

// File: tb/tb_coord_display_driver.sv
// tb_coord_display_driver: scoreboard bench, expected displays queued at stimulus and checked on each update
module tb_coord_display_driver;
  typedef struct {int x; int y; bit xo; bit yo;} exp_t;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int checks = 0, failures = 0;
  exp_t q1[$], q2[$];
  exp_t cur1, cur2;
  int busy_n1, busy_n2, last1, last2, hold1, hold2, n;
  logic pb1, pb2;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int p10 [4] = '{1, 10, 100, 1000};
  coord_display_driver_if b1();
  coord_display_driver_if b2();
  coord_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut1 (.Clk(clk), .Reset(rst_n),  .bus(b1));
  coord_display_driver #(.REFRESH_DIV(2), .BLANK_LZ(1'b0)) dut2 (.Clk(clk), .Reset(rst2_n), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  function automatic logic [6:0] exp_seg(input int xv, input int yv, input int idx, input bit blz);
    int v = (idx >= 4) ? xv : yv;
    int k = idx % 4;
    if (blz && k > 0 && v < p10[k]) return 7'b1111111;
    return seg_tab[(v / p10[k]) % 10];
  endfunction
  task automatic scan_chk(input string nm, input int div, input bit blz, input exp_t cur,
                          input logic [7:0] an, input logic [6:0] seg, input logic dp,
                          inout int last, inout int hold);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (an == 8'(~(8'd1 << i))) idx = i;
    chk({nm, " an_onecold"}, int'(idx >= 0), 1);
    if (idx < 0) return;
    chk({nm, " seg"}, int'(seg), int'(exp_seg(cur.x, cur.y, idx, blz)));
    chk({nm, " dp"}, int'(dp), int'(idx != 4));
    if (idx == last) hold++;
    else begin
      if (hold > 0) begin
        chk({nm, " hold"}, hold, div);
        chk({nm, " next_idx"}, idx, (last + 1) % 8);
      end
      hold = (last < 0) ? -1000 : 1;
      last = idx;
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      cur1 = '{0, 0, 1'b0, 1'b0};
      busy_n1 = 0; pb1 = 1'b0; last1 = -1; hold1 = -1000;
    end else begin
      if (b1.Busy) busy_n1++;
      if (pb1 && !b1.Busy) begin
        chk("u1 busy_len", busy_n1, 29);
        busy_n1 = 0;
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL u1 unexpected_update got=update exp=none");
        end else begin
          cur1 = q1.pop_front();
          chk("u1 xovf", int'(b1.XOvf), int'(cur1.xo));
          chk("u1 yovf", int'(b1.YOvf), int'(cur1.yo));
        end
      end
      pb1 = b1.Busy;
      scan_chk("u1", 4, 1'b1, cur1, b1.An, b1.Seg, b1.Dp, last1, hold1);
    end
  end
  always @(negedge clk) begin
    if (!rst2_n) begin
      q2.delete();
      cur2 = '{0, 0, 1'b0, 1'b0};
      busy_n2 = 0; pb2 = 1'b0; last2 = -1; hold2 = -1000;
    end else begin
      if (b2.Busy) busy_n2++;
      if (pb2 && !b2.Busy) begin
        chk("u2 busy_len", busy_n2, 29);
        busy_n2 = 0;
        if (q2.size() == 0) begin
          checks++; failures++;
          $display("FAIL u2 unexpected_update got=update exp=none");
        end else begin
          cur2 = q2.pop_front();
          chk("u2 xovf", int'(b2.XOvf), int'(cur2.xo));
          chk("u2 yovf", int'(b2.YOvf), int'(cur2.yo));
        end
      end
      pb2 = b2.Busy;
      scan_chk("u2", 2, 1'b0, cur2, b2.An, b2.Seg, b2.Dp, last2, hold2);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_for(input logic v);
    int k = 0;
    while (b1.Busy !== v && k < 200) begin
      tick;
      k++;
    end
    if (b1.Busy !== v) begin
      checks++; failures++;
      $display("FAIL busy_timeout got=%0b exp=%0b", b1.Busy, v);
    end
  endtask
  task automatic apply(input int xi, input int yi, input int xv, input int yv, input bit xo, input bit yo);
    b1.xCoord = xi;
    b1.yCoord = yi;
    q1.push_back('{xv, yv, xo, yo});
    wait_for(1'b1);
    wait_for(1'b0);
    repeat (40) tick;
  endtask
  task automatic reset_outs(input string nm, input logic [7:0] an, input logic [6:0] seg,
                            input logic dp, input logic busy, input logic xo, input logic yo);
    chk({nm, " an"}, int'(an), 'hFE);
    chk({nm, " seg"}, int'(seg), 'h40);
    chk({nm, " dp"}, int'(dp), 1);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " ovf"}, int'({xo, yo}), 0);
  endtask
  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    b1.xCoord = 0; b1.yCoord = 0;
    b2.xCoord = 7; b2.yCoord = 56;
    repeat (3) tick;
    reset_outs("rst1", b1.An, b1.Seg, b1.Dp, b1.Busy, b1.XOvf, b1.YOvf);
    reset_outs("rst2", b2.An, b2.Seg, b2.Dp, b2.Busy, b2.XOvf, b2.YOvf);
    rst_n = 1'b1; rst2_n = 1'b1;
    q2.push_back('{7, 56, 1'b0, 1'b0});
    n = 0;
    repeat (100) begin
      tick;
      if (b1.Busy) n++;
    end
    chk("idle_after_reset busy_cycles", n, 0);
    apply(1234, 56, 1234, 56, 1'b0, 1'b0);
    apply(10000, 9999, 9999, 9999, 1'b1, 1'b0);
    apply(0, 9999, 0, 9999, 1'b0, 1'b0);
    b1.xCoord = 1;
    q1.push_back('{1, 9999, 1'b0, 1'b0});
    wait_for(1'b1);
    repeat (5) tick;
    b1.xCoord = 77;
    q1.push_back('{77, 9999, 1'b0, 1'b0});
    wait_for(1'b0);
    tick;
    chk("recapture busy", int'(b1.Busy), 1);
    wait_for(1'b0);
    repeat (40) tick;
    b1.xCoord = 42;
    q1.push_back('{42, 9999, 1'b0, 1'b0});
    wait_for(1'b1);
    repeat (21) tick;
    rst_n = 1'b0;
    #1;
    reset_outs("midrst", b1.An, b1.Seg, b1.Dp, b1.Busy, b1.XOvf, b1.YOvf);
    tick;
    tick;
    rst_n = 1'b1;
    q1.push_back('{42, 9999, 1'b0, 1'b0});
    tick;
    chk("post_reset capture busy", int'(b1.Busy), 1);
    wait_for(1'b0);
    repeat (40) tick;
    chk("u1 queue_drained", q1.size(), 0);
    chk("u2 queue_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
